// File: rtl/nn_layer_seq_if.sv
// Bus bundle for nn_layer_seq: input vector stream, result stream, coefficient
// write port and status. The layer sits on the slave side.
interface nn_layer_seq_if #(
   parameter int N_IN  = 20,
   parameter int IN_W  = 1,
   parameter int N_OUT = 4,
   parameter int W_W   = 8,
   parameter int OUT_W = 8
);
   localparam int CFG_AW = $clog2(N_OUT * (N_IN + 1));

   // Handshakes: a transfer happens on the rising edge where valid and ready are
   // both high. The producer holds valid/data until that edge; ready never depends
   // combinationally on valid in this design.
   logic                     in_valid;
   logic                     in_ready;
   logic [N_IN*IN_W-1:0]     in_data;
   logic                     act_mode;
   logic                     out_valid;
   logic                     out_ready;
   logic [N_OUT*OUT_W-1:0]   out_data;
   logic                     cfg_we;
   logic [CFG_AW-1:0]        cfg_addr;
   logic [W_W-1:0]           cfg_wdata;
   logic                     busy;

   modport master (
      output in_valid, in_data, act_mode, out_ready, cfg_we, cfg_addr, cfg_wdata,
      input  in_ready, out_valid, out_data, busy
   );

   modport slave (
      input  in_valid, in_data, act_mode, out_ready, cfg_we, cfg_addr, cfg_wdata,
      output in_ready, out_valid, out_data, busy
   );
endinterface

// File: rtl/nn_layer_seq.sv
// Time-multiplexed fully-connected layer: one signed MAC per clock over N_OUT
// neurons of N_IN unsigned inputs, with runtime-loadable weights and biases.
module nn_layer_seq #(
   parameter int N_IN  = 20,
   parameter int IN_W  = 1,
   parameter int N_OUT = 4,
   parameter int W_W   = 8,
   parameter int OUT_W = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   nn_layer_seq_if.slave   bus,
   output logic [1:0]      dbg_state_o
);
   localparam int ACC_W  = W_W + IN_W + $clog2(N_IN + 1) + 1;
   localparam int N_COEF = N_OUT * (N_IN + 1);
   localparam int CFG_AW = $clog2(N_COEF);
   localparam int IW     = (N_IN > 1) ? $clog2(N_IN) : 1;
   localparam int JW     = (N_OUT > 1) ? $clog2(N_OUT) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                     state_q, state_d;
   logic [N_IN*IN_W-1:0]       x_q, x_d;
   logic                       mode_q, mode_d;
   logic signed [ACC_W-1:0]    acc_q, acc_d;
   logic [IW-1:0]              i_q, i_d;
   logic [JW-1:0]              j_q, j_d;
   logic [N_OUT*OUT_W-1:0]     out_q, out_d;
   logic signed [W_W-1:0]      coef_q [N_COEF];

   logic signed [W_W-1:0]      w_cur;
   logic [IN_W-1:0]            x_cur;
   logic signed [ACC_W-1:0]    prod;
   logic signed [ACC_W-1:0]    sum;

   function automatic logic [CFG_AW-1:0] coef_addr(input int j, input int i);
      return CFG_AW'(j * (N_IN + 1) + i);
   endfunction

   // Step fires only on a strictly positive sum; ReLU clamps to the slot range.
   function automatic logic [OUT_W-1:0] activate(input logic signed [ACC_W-1:0] a,
                                                 input logic m);
      longint v;
      longint sat;
      v   = longint'(a);
      sat = (longint'(1) << OUT_W) - 1;
      activate = '0;
      if (!m) begin
         if (v > 0) activate = OUT_W'(1);
      end else if (v <= 0) begin
         activate = '0;
      end else if (v >= sat) begin
         activate = '1;
      end else begin
         activate = v[OUT_W-1:0];
      end
   endfunction

   assign w_cur = coef_q[coef_addr(int'(j_q), int'(i_q))];
   assign x_cur = x_q[int'(i_q)*IN_W +: IN_W];
   assign prod  = ACC_W'(w_cur) * ACC_W'($signed({1'b0, x_cur}));
   assign sum   = acc_q + prod;

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      mode_d  = mode_q;
      acc_d   = acc_q;
      i_d     = i_q;
      j_d     = j_q;
      out_d   = out_q;
      case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               x_d     = bus.in_data;
               mode_d  = bus.act_mode;
               acc_d   = ACC_W'(coef_q[coef_addr(0, N_IN)]);
               i_d     = '0;
               j_d     = '0;
               state_d = S_BUSY;
            end
         end
         S_BUSY: begin
            if (int'(i_q) == N_IN - 1) begin
               out_d[int'(j_q)*OUT_W +: OUT_W] = activate(sum, mode_q);
               i_d   = '0;
               acc_d = sum;
               if (int'(j_q) == N_OUT - 1) begin
                  state_d = S_DONE;
               end else begin
                  j_d   = j_q + JW'(1);
                  acc_d = ACC_W'(coef_q[coef_addr(int'(j_q) + 1, N_IN)]);
               end
            end else begin
               i_d   = i_q + IW'(1);
               acc_d = sum;
            end
         end
         S_DONE: begin
            if (bus.out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         x_q     <= '0;
         mode_q  <= 1'b0;
         acc_q   <= '0;
         i_q     <= '0;
         j_q     <= '0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         mode_q  <= mode_d;
         acc_q   <= acc_d;
         i_q     <= i_d;
         j_q     <= j_d;
         out_q   <= out_d;
      end
   end

   // Coefficients change only between vectors so a running sum never sees a mix.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < N_COEF; k++) coef_q[k] <= '0;
      end else if (bus.cfg_we && state_q == S_IDLE && int'(bus.cfg_addr) < N_COEF) begin
         coef_q[bus.cfg_addr] <= bus.cfg_wdata;
      end
   end

   assign bus.in_ready  = (state_q == S_IDLE);
   assign bus.busy      = (state_q == S_BUSY);
   assign bus.out_valid = (state_q == S_DONE);
   assign bus.out_data  = out_q;
   assign dbg_state_o   = state_q;
endmodule

// File: doc/nn_layer_seq.md
# nn_layer_seq

Parametrised, time-multiplexed fully-connected neural layer. It computes N_OUT neurons over an N_IN-element unsigned input vector using one signed multiply-accumulate per clock. Weights and biases are runtime-loadable, and the activation is selectable per vector. It replaces the fixed combinational binary layer driven from GPIO, with the same default shape (20 inputs, 4 outputs), and adds valid/ready handshakes so it can sit between a sampler and an output or display stage.

## Interface
- N_IN, 20, input vector length (≥1)
- IN_W, 1, bits per input element, unsigned
- N_OUT, 4, neuron count (≥1)
- W_W, 8, weight/bias width, two's complement
- OUT_W, 8, bits per output slot
- Derived: ACC_W = W_W + IN_W + clog2(N_IN+1) + 1, signed accumulator; overflow is impossible
- Derived: CFG_AW = clog2(N_OUT*(N_IN+1))
- clk  in  1  single clock, all logic rising-edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input vector offered
- in_ready  out  1  high only in IDLE
- in_data  in  N_IN*IN_W  element i at bits [i*IN_W +: IN_W]
- act_mode  in  1  0 = step, 1 = saturating ReLU; sampled with in_data
- out_valid  out  1  result vector available
- out_ready  in  1  consumer accepts result
- out_data  out  N_OUT*OUT_W  neuron j at bits [j*OUT_W +: OUT_W]
- cfg_we  in  1  coefficient write strobe
- cfg_addr  in  CFG_AW  coefficient address
- cfg_wdata  in  W_W  coefficient value
- busy  out  1  high in BUSY

## Operation
- Coefficient map: addr = j*(N_IN+1) + i. For i < N_IN it holds weight w[j][i]; i = N_IN holds bias b[j].
- cfg_we is honoured only in IDLE; it is ignored in BUSY/DONE. Addresses ≥ N_OUT*(N_IN+1) are ignored. A write takes effect on the next edge.
- Product: w[j][i] (signed) × x[i], with x zero-extended to IN_W+1 bits signed. The sum is sign-extended to ACC_W.
- Activation is applied to the final acc of neuron j:
  - Mode 0 (step): out = 1 if acc > 0, else 0, zero-extended to OUT_W.
  - Mode 1 (ReLU): out = 0 if acc ≤ 0; 2^OUT_W−1 if acc ≥ 2^OUT_W−1; else acc[OUT_W-1:0].
- FSM:
  - IDLE: in_ready=1. On in_valid, latch in_data and act_mode; set acc ← b[0], j←0, i←0; go to BUSY.
  - BUSY: each cycle acc ← acc + w[j][i]·x[i]; i++.
    - When i = N_IN−1, write the activated sum into slot j.
    - If j = N_OUT−1, go to DONE; otherwise j++, i←0, acc ← b[j+1].
  - DONE: out_valid=1. On out_ready, go to IDLE.
- out_data holds the last result until the next result overwrites its slots. Slots are overwritten progressively during BUSY; out_data is valid only while out_valid=1.
- Latched input and mode are immune to in_data/act_mode changes after acceptance.
- Reset (any state, including mid-BUSY) forces:
  - state IDLE, out_valid=0, busy=0, out_data=0, acc=0, i=j=0
  - all coefficients = 0
  - The in-flight vector is discarded.

## Timing
- Accept edge = edge where in_valid & in_ready.
- busy is high for exactly N_OUT*N_IN cycles after the accept edge.
- out_valid rises N_OUT*N_IN edges after the accept edge (80 with defaults) and stays high until the edge with out_ready=1.
- out_valid falls on the edge after the handshake; in_ready rises on that same edge.
- Minimum vector period is N_OUT*N_IN + 2 cycles: one IDLE, N·M BUSY, one DONE.
- No input/output overlap: in_ready=0 throughout BUSY and DONE.
- in_ready and busy decode from state only; they have no combinational path from in_valid or out_ready.
- Coefficient reads are registered-array lookups in the same cycle. No extra pipeline stage.

## Test plan
- Reset, no cfg writes, in_data all ones, mode 0 -> out_valid rises exactly 80 cycles after accept; out_data=0 (acc=0 is not >0).
- Neuron 2 weights all +1, bias −10, mode 0 -> 10 ones gives slot 2 = 0; 11 ones gives slot 2 = 1. Other slots stay 0.
- Mode 1, neuron 0 weights +127, bias 0, all-ones input -> slot 0 = 255 (acc 2540 saturates). Weights −1 -> slot 0 = 0. Weights +1 with 7 ones -> slot 0 = 7.
- Backpressure: hold out_ready=0 for 50 cycles in DONE with in_valid=1 and cfg_we pulsing -> out_valid/out_data stable, in_ready=0, coefficients unchanged. Release -> in_ready=1 on the next cycle.
- Assert rst_n=0 at BUSY cycle 40 -> out_valid=0, busy=0, in_ready=1 immediately. Next vector yields out_data=0 (coefficients cleared).
- Write cfg_addr=20 (b[0]) = 5 and cfg_addr=84 (out of range), mode 0, zero input -> slot 0 = 1; no other slot changes.
